// File: rtl/parameterized_arb_mux_if.sv
// Bundles the N-producer / one-consumer handshake bus of parameterized_arb_mux.
// Latency: none; this is a plain signal bundle.
// Backpressure: carried by o_in_ready (per channel) and i_out_ready (consumer).
interface parameterized_arb_mux_if #(
    parameter int BW_DATA = 32,
    parameter int IN_NUM  = 4
);
    localparam int BW_SEL = $clog2(IN_NUM);

    // Producer side: flat channel data, channel k at [k*BW_DATA +: BW_DATA]
    logic [BW_DATA*IN_NUM-1:0] i_in_data;
    logic [IN_NUM-1:0]         i_in_valid;
    logic [IN_NUM-1:0]         o_in_ready;

    // Consumer side
    logic [BW_DATA-1:0]        o_out_data;
    logic                      o_out_valid;
    logic                      i_out_ready;
    logic [BW_SEL-1:0]         o_out_sel;

    // Environment view: drives producers and the consumer's ready
    modport master (
        output i_in_data,
        output i_in_valid,
        output i_out_ready,
        input  o_in_ready,
        input  o_out_data,
        input  o_out_valid,
        input  o_out_sel
    );

    // Arbiter view
    modport slave (
        input  i_in_data,
        input  i_in_valid,
        input  i_out_ready,
        output o_in_ready,
        output o_out_data,
        output o_out_valid,
        output o_out_sel
    );
endinterface

// File: rtl/parameterized_arb_mux.sv
// Registered N-to-1 arbitrating mux: picks one valid channel per cycle into a single output register.
// Latency: one cycle from input handshake to o_out_valid; sustains one beat per cycle.
// Backpressure: while the register is full and the consumer stalls, no channel is granted.
// Option: define PARAMETERIZED_ARB_MUX_RR_EN for round-robin; otherwise lowest-index channel wins.
module parameterized_arb_mux #(
    parameter int BW_DATA = 32,
    parameter int IN_NUM  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    parameterized_arb_mux_if.slave bus
);
    localparam int BW_SEL = $clog2(IN_NUM);
    localparam logic [BW_SEL-1:0] LAST_CH = BW_SEL'(IN_NUM - 1);

    // The output register is either empty or holding one beat
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [BW_DATA-1:0]  data_q, data_d;
    logic [BW_SEL-1:0]   sel_q, sel_d;

    // Channel index where the grant search begins
    logic [BW_SEL-1:0]   ptr;

`ifdef PARAMETERIZED_ARB_MUX_RR_EN
    logic [BW_SEL-1:0]   ptr_q, ptr_d;
    assign ptr = ptr_q;
`else
    // Fixed priority: the search always starts at channel 0
    assign ptr = '0;
`endif

    logic                load;
    logic                any_vld;
    logic [BW_SEL-1:0]   grant;
    logic [IN_NUM-1:0]   ready;

    // Channel reached k steps after base, wrapping IN_NUM-1 -> 0 (IN_NUM need not be a power of two)
    function automatic logic [BW_SEL-1:0] chan_at(input logic [BW_SEL-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= IN_NUM) begin
            s = s - IN_NUM;
        end
        return BW_SEL'(s);
    endfunction

    // The register can take a beat when it is empty or being drained this cycle
    assign load    = (state_q == ST_EMPTY) || bus.i_out_ready;
    assign any_vld = |bus.i_in_valid;

    // First valid channel at or after ptr; scanning backwards lets the nearest one win last
    always_comb begin
        grant = '0;
        for (int k = IN_NUM - 1; k >= 0; k--) begin
            if (bus.i_in_valid[chan_at(ptr, k)]) begin
                grant = chan_at(ptr, k);
            end
        end
    end

    // One-hot ready for the granted channel; held low throughout reset
    always_comb begin
        ready = '0;
        if (!i_rst && load && any_vld) begin
            ready[grant] = 1'b1;
        end
    end

    // Next output-stage contents: capture the granted beat, go empty on an idle drain, else hold
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sel_d   = sel_q;
`ifdef PARAMETERIZED_ARB_MUX_RR_EN
        ptr_d   = ptr_q;
`endif
        if (load) begin
            if (any_vld) begin
                state_d = ST_FULL;
                data_d  = bus.i_in_data[int'(grant)*BW_DATA +: BW_DATA];
                sel_d   = grant;
`ifdef PARAMETERIZED_ARB_MUX_RR_EN
                // Winner drops to lowest priority on the next search
                ptr_d   = (grant == LAST_CH) ? '0 : grant + BW_SEL'(1);
`endif
            end else begin
                state_d = ST_EMPTY;
            end
        end
    end

    // Output register and pointer; reset discards any held beat immediately
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= '0;
`ifdef PARAMETERIZED_ARB_MUX_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
`ifdef PARAMETERIZED_ARB_MUX_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.o_in_ready  = ready;
    assign bus.o_out_valid = (state_q == ST_FULL);
    assign bus.o_out_data  = data_q;
    assign bus.o_out_sel   = sel_q;

    // At most one channel is granted, and only one that is offering a beat
    a_ready_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
        $onehot0(bus.o_in_ready));
    a_ready_needs_valid: assert property (@(posedge i_clk) disable iff (i_rst)
        (bus.o_in_ready & ~bus.i_in_valid) == '0);

endmodule

// File: tb/tb_parameterized_arb_mux.sv
// Self-checking bench for parameterized_arb_mux: directed scenarios plus a randomized run.
// Latency: outputs checked 1 time unit after each rising edge, ready checked mid-cycle.
// Backpressure: consumer ready is driven directly and randomized in the random run.
module tb_parameterized_arb_mux;
    localparam int BW = 8;
    localparam int N4 = 4;
    localparam int N3 = 3;

`ifdef PARAMETERIZED_ARB_MUX_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_rst;
    always #5 i_clk = ~i_clk;

    parameterized_arb_mux_if #(.BW_DATA(BW), .IN_NUM(N4)) bus4 ();
    parameterized_arb_mux_if #(.BW_DATA(BW), .IN_NUM(N3)) bus3 ();

    parameterized_arb_mux #(.BW_DATA(BW), .IN_NUM(N4)) dut4 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus4)
    );

    parameterized_arb_mux #(.BW_DATA(BW), .IN_NUM(N3)) dut3 (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus3)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model of the 4-channel instance: one output slot plus a search start
    bit          m_vld;
    logic [7:0]  m_dat;
    int          m_sel;
    int          m_ptr;

    function automatic int pick(input logic [3:0] vld, input int start, input int n);
        for (int k = 0; k < n; k++) begin
            if (vld[(start + k) % n]) return (start + k) % n;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready();
        int g;
        g = pick(bus4.i_in_valid, m_ptr, N4);
        if ((!m_vld || bus4.i_out_ready) && g >= 0) return 4'(1 << g);
        return 4'b0000;
    endfunction

    task automatic model_reset();
        m_vld = 1'b0;
        m_dat = 8'h00;
        m_sel = 0;
        m_ptr = 0;
    endtask

    // Advance one clock, updating the model with what the producers/consumer offered at the edge
    task automatic tick();
        int g;
        @(posedge i_clk);
        if (!m_vld || bus4.i_out_ready) begin
            g = pick(bus4.i_in_valid, m_ptr, N4);
            if (g >= 0) begin
                m_dat = bus4.i_in_data[g*BW +: BW];
                m_sel = g;
                m_vld = 1'b1;
                m_ptr = RR ? (g + 1) % N4 : 0;
            end else begin
                m_vld = 1'b0;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        bus4.i_in_valid  = '0;
        bus4.i_in_data   = '0;
        bus4.i_out_ready = 1'b0;
        bus3.i_in_valid  = '0;
        bus3.i_in_data   = '0;
        bus3.i_out_ready = 1'b0;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        clear_inputs();
        model_reset();
        #3;
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        bus4.i_in_valid  = 4'b1111;
        bus4.i_in_data   = 32'h13121110;
        bus4.i_out_ready = 1'b1;
        #1;
        n_vec++;
        if (bus4.o_in_ready !== 4'b0000) begin
            n_err++; $display("FAIL rst_ready: got %b want 0000", bus4.o_in_ready);
        end
        n_vec++;
        if ({bus4.o_out_valid, bus4.o_out_data, bus4.o_out_sel} !== 11'd0) begin
            n_err++; $display("FAIL rst_outputs: got v=%b d=%h s=%0d want all 0",
                              bus4.o_out_valid, bus4.o_out_data, bus4.o_out_sel);
        end
        @(posedge i_clk); #1;
        n_vec++;
        if (bus4.o_out_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_held_edge: got valid=%b want 0", bus4.o_out_valid);
        end
        do_reset();
    endtask

    task automatic test_reset_midstream();
        do_reset();
        bus4.i_in_valid = 4'b0010;
        bus4.i_in_data  = 32'h00003C00;
        #2;
        n_vec++;
        if (bus4.o_in_ready !== 4'b0010) begin
            n_err++; $display("FAIL mid_load_ready: got %b want 0010", bus4.o_in_ready);
        end
        tick();
        bus4.i_in_valid = 4'b1111;
        bus4.i_in_data  = 32'h13121110;
        n_vec++;
        if (bus4.o_out_valid !== 1'b1 || bus4.o_out_data !== 8'h3C) begin
            n_err++; $display("FAIL mid_full: got v=%b d=%h want v=1 d=3c", bus4.o_out_valid, bus4.o_out_data);
        end
        #2;
        i_rst = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if (bus4.o_out_valid !== 1'b0 || bus4.o_out_data !== 8'h00 || bus4.o_out_sel !== 2'd0) begin
            n_err++; $display("FAIL mid_async_rst: got v=%b d=%h s=%0d want 0/00/0",
                              bus4.o_out_valid, bus4.o_out_data, bus4.o_out_sel);
        end
        n_vec++;
        if (bus4.o_in_ready !== 4'b0000) begin
            n_err++; $display("FAIL mid_rst_ready: got %b want 0000", bus4.o_in_ready);
        end
        i_rst = 1'b0;
        bus4.i_out_ready = 1'b1;
        #2;
        n_vec++;
        if (bus4.o_in_ready !== 4'b0001) begin
            n_err++; $display("FAIL post_rst_ready: got %b want 0001", bus4.o_in_ready);
        end
        tick();
        n_vec++;
        if (bus4.o_out_sel !== 2'd0 || bus4.o_out_data !== 8'h10) begin
            n_err++; $display("FAIL post_rst_grant: got s=%0d d=%h want s=0 d=10", bus4.o_out_sel, bus4.o_out_data);
        end
    endtask

    task automatic test_single();
        do_reset();
        bus4.i_in_valid  = 4'b0100;
        bus4.i_in_data   = 32'h11A52233;
        bus4.i_out_ready = 1'b1;
        #2;
        n_vec++;
        if (bus4.o_in_ready !== 4'b0100) begin
            n_err++; $display("FAIL single_ready: got %b want 0100", bus4.o_in_ready);
        end
        tick();
        bus4.i_in_valid = 4'b0000;
        n_vec++;
        if (bus4.o_out_valid !== 1'b1 || bus4.o_out_data !== 8'hA5 || bus4.o_out_sel !== 2'd2) begin
            n_err++; $display("FAIL single_out: got v=%b d=%h s=%0d want 1/a5/2",
                              bus4.o_out_valid, bus4.o_out_data, bus4.o_out_sel);
        end
    endtask

    task automatic test_all_valid();
        int exp_seq [6];
        if (RR) exp_seq = '{0, 1, 2, 3, 0, 1};
        else    exp_seq = '{0, 0, 0, 0, 0, 0};
        do_reset();
        bus4.i_in_valid  = 4'b1111;
        bus4.i_in_data   = 32'h13121110;
        bus4.i_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_vec++;
            if (bus4.o_out_valid !== 1'b1 || int'(bus4.o_out_sel) !== exp_seq[i]
                || bus4.o_out_data !== 8'(8'h10 + exp_seq[i])) begin
                n_err++; $display("FAIL all_valid_seq[%0d]: got v=%b s=%0d d=%h want s=%0d",
                                  i, bus4.o_out_valid, bus4.o_out_sel, bus4.o_out_data, exp_seq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_rdy;
        do_reset();
        bus4.i_in_valid  = 4'b0001;
        bus4.i_in_data   = 32'h00000077;
        bus4.i_out_ready = 1'b1;
        tick();
        bus4.i_in_valid  = 4'b1111;
        bus4.i_in_data   = 32'h23222120;
        bus4.i_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            n_vec++;
            if (bus4.o_in_ready !== 4'b0000) begin
                n_err++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, bus4.o_in_ready);
            end
            tick();
            n_vec++;
            if (bus4.o_out_valid !== 1'b1 || bus4.o_out_data !== 8'h77 || bus4.o_out_sel !== 2'd0) begin
                n_err++; $display("FAIL bp_hold[%0d]: got v=%b d=%h s=%0d want 1/77/0",
                                  i, bus4.o_out_valid, bus4.o_out_data, bus4.o_out_sel);
            end
        end
        bus4.i_out_ready = 1'b1;
        exp_rdy = RR ? 4'b0010 : 4'b0001;
        #2;
        n_vec++;
        if (bus4.o_in_ready !== exp_rdy) begin
            n_err++; $display("FAIL bp_release_ready: got %b want %b", bus4.o_in_ready, exp_rdy);
        end
        tick();
        n_vec++;
        if (bus4.o_out_valid !== 1'b1 || bus4.o_out_data !== (RR ? 8'h21 : 8'h20)) begin
            n_err++; $display("FAIL bp_no_bubble: got v=%b d=%h want v=1 d=%h",
                              bus4.o_out_valid, bus4.o_out_data, RR ? 8'h21 : 8'h20);
        end
    endtask

    // Continues from the state left by test_backpressure
    task automatic test_drain();
        logic [7:0] last;
        logic [3:0] exp_rdy;
        last = RR ? 8'h21 : 8'h20;
        bus4.i_in_valid  = 4'b0000;
        bus4.i_out_ready = 1'b1;
        tick();
        n_vec++;
        if (bus4.o_out_valid !== 1'b0 || bus4.o_out_data !== last) begin
            n_err++; $display("FAIL drain_empty: got v=%b d=%h want v=0 d=%h", bus4.o_out_valid, bus4.o_out_data, last);
        end
        bus4.i_in_valid = 4'b1111;
        exp_rdy = RR ? 4'b0100 : 4'b0001;
        #2;
        n_vec++;
        if (bus4.o_in_ready !== exp_rdy) begin
            n_err++; $display("FAIL drain_ptr_ready: got %b want %b", bus4.o_in_ready, exp_rdy);
        end
        tick();
        n_vec++;
        if (int'(bus4.o_out_sel) !== (RR ? 2 : 0)) begin
            n_err++; $display("FAIL drain_ptr_sel: got %0d want %0d", bus4.o_out_sel, RR ? 2 : 0);
        end
    endtask

    task automatic test_wrap3();
        do_reset();
        bus3.i_in_valid  = 3'b100;
        bus3.i_in_data   = 24'h520000;
        bus3.i_out_ready = 1'b1;
        #2;
        n_vec++;
        if (bus3.o_in_ready !== 3'b100) begin
            n_err++; $display("FAIL wrap_ready_ch2: got %b want 100", bus3.o_in_ready);
        end
        tick();
        n_vec++;
        if (bus3.o_out_sel !== 2'd2 || bus3.o_out_data !== 8'h52) begin
            n_err++; $display("FAIL wrap_ch2: got s=%0d d=%h want 2/52", bus3.o_out_sel, bus3.o_out_data);
        end
        bus3.i_in_valid = 3'b011;
        bus3.i_in_data  = 24'h005150;
        #2;
        n_vec++;
        if (bus3.o_in_ready !== 3'b001) begin
            n_err++; $display("FAIL wrap_ready_ch0: got %b want 001", bus3.o_in_ready);
        end
        tick();
        n_vec++;
        if (bus3.o_out_sel !== 2'd0 || bus3.o_out_data !== 8'h50) begin
            n_err++; $display("FAIL wrap_ch0: got s=%0d d=%h want 0/50", bus3.o_out_sel, bus3.o_out_data);
        end
        bus3.i_in_valid = 3'b010;
        #2;
        n_vec++;
        if (bus3.o_in_ready !== 3'b010) begin
            n_err++; $display("FAIL wrap_ready_ch1: got %b want 010", bus3.o_in_ready);
        end
        tick();
        n_vec++;
        if (bus3.o_out_sel !== 2'd1 || bus3.o_out_data !== 8'h51 || bus3.o_out_valid !== 1'b1) begin
            n_err++; $display("FAIL wrap_ch1: got s=%0d d=%h v=%b want 1/51/1",
                              bus3.o_out_sel, bus3.o_out_data, bus3.o_out_valid);
        end
        bus3.i_in_valid = 3'b000;
    endtask

    // Random producers that hold their beat until taken, random consumer stalls
    task automatic test_random();
        logic [3:0] exp_rdy;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < N4; c++) begin
                if (!bus4.i_in_valid[c]) begin
                    bus4.i_in_valid[c] = ($urandom_range(0, 2) == 0);
                    bus4.i_in_data[c*BW +: BW] = 8'($urandom);
                end
            end
            bus4.i_out_ready = ($urandom_range(0, 3) != 0);
            #2;
            exp_rdy = model_ready();
            n_vec++;
            if (bus4.o_in_ready !== exp_rdy) begin
                n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", i, bus4.o_in_ready, exp_rdy);
            end
            tick();
            n_vec++;
            if (bus4.o_out_valid !== m_vld || bus4.o_out_data !== m_dat || int'(bus4.o_out_sel) !== m_sel) begin
                n_err++; $display("FAIL rand_out[%0d]: got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                                  i, bus4.o_out_valid, bus4.o_out_data, bus4.o_out_sel, m_vld, m_dat, m_sel);
            end
            bus4.i_in_valid = bus4.i_in_valid & ~exp_rdy;
        end
    endtask

    initial begin
        i_rst = 1'b1;
        clear_inputs();
        model_reset();
        test_reset();
        test_reset_midstream();
        test_single();
        test_all_valid();
        test_backpressure();
        test_drain();
        test_wrap3();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/parameterized_arb_mux.md
# parameterized_arb_mux

Registered N-to-1 arbitrating multiplexer with valid/ready handshakes on every input channel and on the output. It is the successor to the plain combinational parameterized mux. Channels arrive on one flat packed bus, and a round-robin arbiter picks the channel instead of an external select. The block sits between multiple producer streams and one shared consumer, adds one register stage, and sustains one beat per cycle.

## Interface
- BW_DATA, 32, data width per channel in bits
- IN_NUM, 4, number of input channels; legal range is 2 and up, power of two not required
- BW_SEL, $clog2(IN_NUM), width of the channel index; localparam, not overridable

Ports:
- i_clk  input  1  single clock; all state changes on its rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_in_data  input  BW_DATA*IN_NUM  flat packed channel data; channel k is at [k*BW_DATA +: BW_DATA]
- i_in_valid  input  IN_NUM  bit k means channel k has a beat
- o_in_ready  output  IN_NUM  bit k means channel k's beat is taken this cycle
- o_out_data  output  BW_DATA  registered output beat
- o_out_valid  output  1  o_out_data holds a valid beat
- i_out_ready  input  1  consumer accepts the output beat
- o_out_sel  output  BW_SEL  source channel of the beat in o_out_data

## Operation
- Output stage has two states, tracked by o_out_valid:
  - EMPTY (o_out_valid=0)
  - FULL (o_out_valid=1)
- load = !o_out_valid || i_out_ready, i.e. the register is free or is draining this cycle.
- Grant g: the first channel with i_in_valid=1, searching from ptr upward and wrapping IN_NUM-1 -> 0.
- o_in_ready[g] = load && |i_in_valid; all other bits are 0. o_in_ready is combinational and at most one-hot.
- Rising edge with load=1 and a valid grant:
  - o_out_data <= channel g data
  - o_out_sel <= g
  - o_out_valid <= 1
  - ptr <= (g==IN_NUM-1) ? 0 : g+1
- Rising edge with load=1 and no valid input: o_out_valid <= 0. o_out_data and o_out_sel hold. ptr holds.
- Rising edge with load=0 (FULL and i_out_ready=0): o_out_data, o_out_sel and ptr all hold.
- Transitions:
  - EMPTY -> FULL on a grant.
  - FULL -> FULL on simultaneous drain and grant, with no bubble.
  - FULL -> EMPTY on drain with no valid input.
- Producers must hold i_in_valid and data until they see their o_in_ready. The block does not check this.
- Reset (asynchronous, at any time, including mid-transfer):
  - o_out_valid=0, o_out_data=0, o_out_sel=0, ptr=0
  - o_in_ready=0 while i_rst is high
  - A beat held in the register is discarded.

## Timing
- Latency: a beat accepted at edge N appears on o_out_data/o_out_valid after edge N.
- Throughput: one beat per cycle while i_out_ready=1 and any input is valid.
- o_in_ready depends combinationally on i_in_valid, i_out_ready, o_out_valid and ptr. There is no combinational path from i_in_data to any output.
- A transfer on an input or on the output happens on a rising edge where valid and ready are both 1.
- Reset values of all outputs: o_out_valid=0, o_out_data=0, o_out_sel=0, o_in_ready=0.

## Configuration
- PARAMETERIZED_ARB_MUX_RR_EN defined: round-robin arbitration with a rotating ptr, as described above.
- Not defined: fixed priority. The lowest-index valid channel always wins, ptr is removed and treated as constant 0, and all other behaviour is identical.

## Test plan
Every scenario uses BW_DATA=8 and IN_NUM=4 unless stated otherwise.
- Reset mid-stream: assert i_rst while FULL with o_out_data=0x3C -> o_out_valid=0, o_out_data=0x00, o_out_sel=0 and o_in_ready=4'b0000 immediately, without waiting for an edge. The first grant after release starts at ch0.
- Single channel: ch2 valid with 0xA5 and i_out_ready=1 -> o_in_ready=4'b0100 that cycle. Next cycle o_out_valid=1, o_out_data=0xA5, o_out_sel=2.
- All four channels valid continuously with data 0x10/0x11/0x12/0x13 and i_out_ready=1:
  - RR_EN: o_out_sel sequence 0,1,2,3,0,1.
  - Without RR_EN: 0,0,0,0.
- Backpressure: fill the output with 0x77, then hold i_out_ready=0 for 5 cycles with all inputs valid -> o_in_ready=0000 and o_out_data=0x77 stable. After i_out_ready=1, the next grant lands with no bubble.
- Wrap with IN_NUM=3 and RR_EN: grant ch2, then ch0 and ch1 both valid -> ch0 granted next (ptr wrapped), then ch1.
- Drain plus load with nothing pending: FULL, i_out_ready=1, no inputs valid -> o_out_valid=0 next cycle, o_out_data holds its last value, and ptr is unchanged.
